// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the program-counter sequencer.
//   state_t        : redirect buffer FSM state (IDLE, DELAY)
//   DEF_RESET_VEC  : default PC loaded on reset
//   DEF_TRAP_VEC   : default PC loaded on trap
//   align_down()   : clears the low log2(inc) bits of an address
package pc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DELAY = 1'b1
  } state_t;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_4180;

  // Widest address the helper handles; callers cast to their own XLEN.
  localparam int unsigned ADDR_MAX = 64;

  // inc is a power of two, so inc-1 is exactly the mask of bits to clear.
  function automatic logic [ADDR_MAX-1:0] align_down(input logic [ADDR_MAX-1:0] addr,
                                                      input int unsigned inc);
    return addr & ~(ADDR_MAX'(inc) - ADDR_MAX'(1));
  endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// pc_redirect_buffer: holds an accepted redirect target while the delay-slot
// fetches drain, and signals when the target is due on the PC.
// Ports:
//   clk, reset     : clock, asynchronous active-low reset
//   flush          : discard any pending target, return to IDLE (trap)
//   load           : capture load_target and start counting delay slots
//   load_target    : aligned redirect target
//   advance        : a non-stalled, non-trap edge (counts one delay slot)
//   idle           : FSM is in IDLE (redirects may be accepted)
//   done           : in DELAY with no slots left; target goes on PC next edge
//   target         : held target
module pc_redirect_buffer
  import pc_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DELAY_SLOTS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] load_target,
  input  logic            advance,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] target
);

  // The load slot itself is the first delay slot, hence the minus one.
  localparam logic [1:0] INIT_REMAINING = (DELAY_SLOTS > 0) ? 2'(DELAY_SLOTS - 1) : 2'd0;

  state_t          state, state_next;
  logic [1:0]      remaining, remaining_next;
  logic [XLEN-1:0] target_q, target_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= 2'd0;
      target_q  <= '0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      target_q  <= target_next;
    end
  end

  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    target_next    = target_q;
    if (flush) begin
      state_next     = IDLE;
      remaining_next = 2'd0;
      target_next    = '0;
    end else if (load) begin
      state_next     = DELAY;
      remaining_next = INIT_REMAINING;
      target_next    = load_target;
    end else if (advance && state == DELAY) begin
      if (remaining != 2'd0) begin
        remaining_next = remaining - 2'd1;
      end else begin
        state_next = IDLE;
      end
    end
  end

  assign idle   = (state == IDLE);
  assign done   = (state == DELAY) && (remaining == 2'd0);
  assign target = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer driving the instruction-fetch
// address every cycle, with configurable delay slots, stall, trap and a
// redirect ready handshake.
// Ports:
//   clk              : clock
//   reset            : asynchronous active-low reset
//   stall            : hold PC and internal state this cycle
//   redirect_valid   : branch/jump target presented
//   redirect_target  : redirect destination
//   trap             : exception; overrides everything except reset
//   redirect_ready   : redirect accepted when high with redirect_valid
//   pc               : current fetch address (registered)
//   in_delay_slot    : pc is a delay-slot fetch
//   misalign         : one-cycle pulse, accepted target had low bits set
//   redirect_dropped : sticky, redirect presented while buffer busy
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC    = XLEN'(DEF_TRAP_VEC),
  parameter int unsigned     INC         = 4,
  parameter int unsigned     DELAY_SLOTS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap,
  output logic            redirect_ready,
  output logic [XLEN-1:0] pc,
  output logic            in_delay_slot,
  output logic            misalign,
  output logic            redirect_dropped
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INC - 1);

  logic            buf_idle, buf_done, accept, advance, load;
  logic [XLEN-1:0] buf_target, target_aligned, pc_inc;
  logic [XLEN-1:0] pc_next;
  logic            in_delay_slot_next, misalign_next, redirect_dropped_next;

  assign advance        = ~stall & ~trap;
  assign redirect_ready = buf_idle & advance;
  assign accept         = redirect_valid & redirect_ready;
  assign load           = accept && (DELAY_SLOTS > 0);
  assign target_aligned = XLEN'(align_down(ADDR_MAX'(redirect_target), INC));
  assign pc_inc         = pc + XLEN'(INC);  // wraps modulo 2^XLEN

  pc_redirect_buffer #(
    .XLEN        (XLEN),
    .DELAY_SLOTS (DELAY_SLOTS)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .flush       (trap),
    .load        (load),
    .load_target (target_aligned),
    .advance     (advance),
    .idle        (buf_idle),
    .done        (buf_done),
    .target      (buf_target)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc               <= RESET_VEC;
      in_delay_slot    <= 1'b0;
      misalign         <= 1'b0;
      redirect_dropped <= 1'b0;
    end else begin
      pc               <= pc_next;
      in_delay_slot    <= in_delay_slot_next;
      misalign         <= misalign_next;
      redirect_dropped <= redirect_dropped_next;
    end
  end

  // Priority: trap > stall > buffer state action.
  always_comb begin
    pc_next               = pc;
    in_delay_slot_next    = in_delay_slot;
    misalign_next         = 1'b0;
    redirect_dropped_next = redirect_dropped;
    if (trap) begin
      pc_next            = TRAP_VEC;
      in_delay_slot_next = 1'b0;
    end else if (stall) begin
      pc_next = pc;
    end else if (buf_idle) begin
      if (accept) begin
        misalign_next = |(redirect_target & LOW_MASK);
        if (DELAY_SLOTS == 0) begin
          pc_next = target_aligned;
        end else begin
          pc_next            = pc_inc;
          in_delay_slot_next = 1'b1;
        end
      end else begin
        pc_next = pc_inc;
      end
    end else begin
      // Busy draining delay slots: a new redirect cannot be taken.
      if (redirect_valid) redirect_dropped_next = 1'b1;
      if (buf_done) begin
        pc_next            = buf_target;
        in_delay_slot_next = 1'b0;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;

  logic        r1_ready, r1_ids, r1_mis, r1_drop;
  logic [31:0] r1_pc;
  logic        r3_ready, r3_ids, r3_mis, r3_drop;
  logic [31:0] r3_pc;
  logic        r0_ready, r0_ids, r0_mis, r0_drop;
  logic [31:0] r0_pc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.DELAY_SLOTS(1)) d1 (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .redirect_ready(r1_ready),
    .pc(r1_pc), .in_delay_slot(r1_ids), .misalign(r1_mis), .redirect_dropped(r1_drop)
  );

  pc_sequencer #(.DELAY_SLOTS(3)) d3 (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .redirect_ready(r3_ready),
    .pc(r3_pc), .in_delay_slot(r3_ids), .misalign(r3_mis), .redirect_dropped(r3_drop)
  );

  pc_sequencer #(.DELAY_SLOTS(0)) d0 (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap), .redirect_ready(r0_ready),
    .pc(r0_pc), .in_delay_slot(r0_ids), .misalign(r0_mis), .redirect_dropped(r0_drop)
  );

  // Inputs change 1ns after the rising edge; outputs sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; trap = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; trap = 1'b0;
    redirect_valid = 1'b0; redirect_target = '0;
    tick(); tick(); tick();
    tests++; if (r1_pc !== 32'h3000) begin fails++; $display("FAIL reset_pc: got %h want %h", r1_pc, 32'h3000); end
    tests++; if (r1_ids !== 1'b0) begin fails++; $display("FAIL reset_ids: got %b want 0", r1_ids); end
    tests++; if (r1_drop !== 1'b0 || r1_mis !== 1'b0) begin fails++; $display("FAIL reset_flags: got drop=%b mis=%b want 0 0", r1_drop, r1_mis); end
    reset = 1'b1;
    tick();
    tests++; if (r1_pc !== 32'h3004) begin fails++; $display("FAIL reset_seq1: got %h want %h", r1_pc, 32'h3004); end
    tick();
    tests++; if (r1_pc !== 32'h3008 || r1_ids !== 1'b0) begin fails++; $display("FAIL reset_seq2: got pc=%h ids=%b want 3008 0", r1_pc, r1_ids); end
    $display("[TB] test_reset pc=%h", r1_pc);
  endtask

  task automatic test_ds1();
    tick();
    tests++; if (r1_pc !== 32'h300C) begin fails++; $display("FAIL ds1_start: got %h want %h", r1_pc, 32'h300C); end
    redirect_valid = 1'b1; redirect_target = 32'h3100;
    #1;
    tests++; if (r1_ready !== 1'b1) begin fails++; $display("FAIL ds1_ready: got %b want 1", r1_ready); end
    tick();
    redirect_valid = 1'b0;
    tests++; if (r1_pc !== 32'h3010 || r1_ids !== 1'b1) begin fails++; $display("FAIL ds1_slot: got pc=%h ids=%b want 3010 1", r1_pc, r1_ids); end
    tick();
    tests++; if (r1_pc !== 32'h3100 || r1_ids !== 1'b0) begin fails++; $display("FAIL ds1_target: got pc=%h ids=%b want 3100 0", r1_pc, r1_ids); end
    tick();
    tests++; if (r1_pc !== 32'h3104) begin fails++; $display("FAIL ds1_after: got %h want %h", r1_pc, 32'h3104); end
    $display("[TB] test_ds1 pc=%h", r1_pc);
  endtask

  task automatic test_ds3_stall();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h5000;
    #1;
    tests++; if (r3_ready !== 1'b1 || r3_pc !== 32'h3000) begin fails++; $display("FAIL ds3_ready: got rdy=%b pc=%h want 1 3000", r3_ready, r3_pc); end
    tick();
    redirect_valid = 1'b0;
    tests++; if (r3_pc !== 32'h3004 || r3_ids !== 1'b1) begin fails++; $display("FAIL ds3_slot1: got pc=%h ids=%b want 3004 1", r3_pc, r3_ids); end
    tick();
    tests++; if (r3_pc !== 32'h3008) begin fails++; $display("FAIL ds3_slot2: got %h want %h", r3_pc, 32'h3008); end
    stall = 1'b1;
    tick();
    tests++; if (r3_pc !== 32'h3008) begin fails++; $display("FAIL ds3_stall1: got %h want %h", r3_pc, 32'h3008); end
    tick();
    tests++; if (r3_pc !== 32'h3008 || r3_drop !== 1'b0) begin fails++; $display("FAIL ds3_stall2: got pc=%h drop=%b want 3008 0", r3_pc, r3_drop); end
    stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h6000;
    #1;
    tests++; if (r3_ready !== 1'b0) begin fails++; $display("FAIL ds3_busy_ready: got %b want 0", r3_ready); end
    tick();
    redirect_valid = 1'b0;
    tests++; if (r3_pc !== 32'h300C || r3_drop !== 1'b1) begin fails++; $display("FAIL ds3_slot3: got pc=%h drop=%b want 300c 1", r3_pc, r3_drop); end
    tick();
    tests++; if (r3_pc !== 32'h5000 || r3_ids !== 1'b0) begin fails++; $display("FAIL ds3_target: got pc=%h ids=%b want 5000 0", r3_pc, r3_ids); end
    tick();
    tests++; if (r3_pc !== 32'h5004 || r3_drop !== 1'b1) begin fails++; $display("FAIL ds3_after: got pc=%h drop=%b want 5004 1", r3_pc, r3_drop); end
    $display("[TB] test_ds3_stall pc=%h", r3_pc);
  endtask

  task automatic test_trap();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h5000;
    tick();
    redirect_valid = 1'b0;
    tests++; if (r3_pc !== 32'h3004) begin fails++; $display("FAIL trap_pre: got %h want %h", r3_pc, 32'h3004); end
    stall = 1'b1; trap = 1'b1;
    tick();
    trap = 1'b0;
    tests++; if (r3_pc !== 32'h4180 || r3_ids !== 1'b0) begin fails++; $display("FAIL trap_vec: got pc=%h ids=%b want 4180 0", r3_pc, r3_ids); end
    tick();
    tests++; if (r3_pc !== 32'h4180) begin fails++; $display("FAIL trap_stall: got %h want %h", r3_pc, 32'h4180); end
    stall = 1'b0;
    #1;
    tests++; if (r3_ready !== 1'b1) begin fails++; $display("FAIL trap_idle_ready: got %b want 1", r3_ready); end
    tick();
    tests++; if (r3_pc !== 32'h4184) begin fails++; $display("FAIL trap_next: got %h want %h", r3_pc, 32'h4184); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (r3_pc !== 32'h4188 + 32'(4 * i)) begin fails++; $display("FAIL trap_no_target: got %h want %h", r3_pc, 32'h4188 + 32'(4 * i)); end
    end
    $display("[TB] test_trap pc=%h", r3_pc);
  endtask

  task automatic test_misalign_wrap();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h3102;
    #1;
    tests++; if (r0_ready !== 1'b1) begin fails++; $display("FAIL mis_ready: got %b want 1", r0_ready); end
    tick();
    redirect_valid = 1'b0;
    tests++; if (r0_pc !== 32'h3100 || r0_mis !== 1'b1) begin fails++; $display("FAIL mis_pulse: got pc=%h mis=%b want 3100 1", r0_pc, r0_mis); end
    tick();
    tests++; if (r0_pc !== 32'h3104 || r0_mis !== 1'b0) begin fails++; $display("FAIL mis_clear: got pc=%h mis=%b want 3104 0", r0_pc, r0_mis); end
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tests++; if (r0_pc !== 32'hFFFF_FFFC || r0_mis !== 1'b0) begin fails++; $display("FAIL wrap_top: got pc=%h mis=%b want fffffffc 0", r0_pc, r0_mis); end
    tick();
    tests++; if (r0_pc !== 32'h0 || r0_mis !== 1'b0) begin fails++; $display("FAIL wrap_zero: got pc=%h mis=%b want 0 0", r0_pc, r0_mis); end
    $display("[TB] test_misalign_wrap pc=%h", r0_pc);
  endtask

  task automatic test_async_reset();
    do_reset();
    redirect_valid = 1'b1; redirect_target = 32'h5000;
    tick();
    tick();  // second cycle lands in DELAY and is dropped
    redirect_valid = 1'b0;
    tests++; if (r3_pc !== 32'h3008 || r3_drop !== 1'b1) begin fails++; $display("FAIL async_pre: got pc=%h drop=%b want 3008 1", r3_pc, r3_drop); end
    #3;
    reset = 1'b0;
    #1;
    tests++; if (r3_pc !== 32'h3000 || r3_ids !== 1'b0 || r3_drop !== 1'b0) begin fails++; $display("FAIL async_reset: got pc=%h ids=%b drop=%b want 3000 0 0", r3_pc, r3_ids, r3_drop); end
    reset = 1'b1;
    tick();
    tests++; if (r3_pc !== 32'h3004 || r3_ids !== 1'b0) begin fails++; $display("FAIL async_after: got pc=%h ids=%b want 3004 0", r3_pc, r3_ids); end
    $display("[TB] test_async_reset pc=%h", r3_pc);
  endtask

  initial begin
    test_reset();
    test_ds1();
    test_ds3_stall();
    test_trap();
    test_misalign_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the single-cycle/multicycle CPU cores; drives the instruction-fetch address every cycle.
- Generalises the fixed single-delay-slot PC to configurable width, reset vector, increment and delay-slot depth (0..3).
- Adds stall hold, a highest-priority trap redirect, a redirect ready handshake and misalignment flagging.
- Sits between branch/jump resolution and instruction memory.

Parameters:
XLEN, 32, PC and target width in bits
RESET_VEC, 32'h0000_3000, PC value loaded on reset
TRAP_VEC, 32'h0000_4180, PC value loaded on trap
INC, 4, sequential increment; power of two, >= 1
DELAY_SLOTS, 1, sequential fetches between an accepted redirect and the target fetch; 0..3

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC and all internal state this cycle
redirect_valid  in  1  branch/jump/jal target presented
redirect_target  in  XLEN  redirect destination
trap  in  1  exception request; overrides everything except reset
redirect_ready  out  1  redirect accepted this cycle when high together with redirect_valid
pc  out  XLEN  current fetch address (registered)
in_delay_slot  out  1  pc is a delay-slot fetch
misalign  out  1  one-cycle pulse: accepted target had nonzero low log2(INC) bits
redirect_dropped  out  1  sticky: redirect_valid seen while redirect_ready low and no stall/trap; cleared only by reset

Behaviour:
- Reset (reset low, async): pc=RESET_VEC, state=IDLE, remaining=0, held target=0, in_delay_slot=0, misalign=0, redirect_dropped=0. Release is synchronised by normal flop timing; first update on the first rising edge with reset high.
- States: IDLE, DELAY. Registers: target_q[XLEN], remaining[1:0].
- redirect_ready = (state==IDLE) & ~stall & ~trap (combinational).
- Priority per edge: trap > stall > state action.
- trap: pc<=TRAP_VEC; state<=IDLE; remaining<=0; pending target discarded; in_delay_slot<=0. Applies even when stall is high.
- stall (no trap): all registers hold; misalign<=0.
- IDLE, redirect accepted:
  - Target is captured with low log2(INC) bits cleared. misalign<=1 if any cleared bit was 1.
  - DELAY_SLOTS==0: pc<=target; stay in IDLE.
  - DELAY_SLOTS>0: pc<=pc+INC; target_q<=target; remaining<=DELAY_SLOTS-1; state<=DELAY; in_delay_slot<=1.
- IDLE, no redirect: pc<=pc+INC.
- DELAY: redirect_valid is ignored and sets redirect_dropped.
  - remaining!=0: pc<=pc+INC; remaining--.
  - remaining==0: pc<=target_q; state<=IDLE; in_delay_slot<=0.
- Arithmetic: pc+INC is modulo 2^XLEN. Example: 32'hFFFF_FFFC+4 wraps to 0; no flag.
- Latency: a redirect accepted at edge N puts target on pc after edge N+DELAY_SLOTS (DELAY_SLOTS=0: after edge N).
- Reset mid-DELAY: pending target lost; pc=RESET_VEC.

Decomposition:
- Package pc_pkg:
  - state enum {IDLE, DELAY}
  - default RESET_VEC/TRAP_VEC constants
  - function align_down(addr, INC)
- One sub-module is natural: pc_redirect_buffer, which holds target_q, remaining and the state FSM and exposes load/advance/flush/done. The top module keeps the pc register and the priority mux.

Test Plan:
- Reset: hold reset low 3 cycles, release -> pc=3000, then 3004, 3008 on successive edges; in_delay_slot=0.
- DELAY_SLOTS=1: at pc=300C assert redirect_valid, target 3100, for 1 cycle -> redirect_ready=1; pc=3010 (in_delay_slot=1), then 3100, then 3104.
- DELAY_SLOTS=3, stall: redirect to 5000 at pc=3000 -> pc sequence 3004, 3008, 300C, 5000. Stall 2 cycles during 3008 -> pc holds 3008 twice, target still 5000; redirect_valid during DELAY sets redirect_dropped=1.
- Trap during DELAY with stall=1 -> next pc=4180, state IDLE, pending target never appears; next unstalled edge gives 4184.
- Misaligned target 3102 with INC=4, DELAY_SLOTS=0 -> pc=3100, misalign pulses 1 cycle; wrap test: pc=FFFFFFFC -> 0.
- Async reset asserted mid-cycle while in DELAY -> pc=3000 immediately, without waiting for a clock edge; redirect_dropped=0.
